// File: rtl/bus_arbiter_if.sv
// Memory-bus bundle between the four bus masters, the arbiter and the single memory slave.
// The arbiter takes the master modport (it masters the slave side); the environment takes slave.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]          mReq;
  logic [3:0]          mWe;
  logic [4*ADDR_W-1:0] mAddr;
  logic [4*DATA_W-1:0] mWdata;
  logic [3:0]          mAck;
  logic [DATA_W-1:0]   mRdata;
  logic                sReq;
  logic                sWe;
  logic [ADDR_W-1:0]   sAddr;
  logic [DATA_W-1:0]   sWdata;
  logic                sAck;
  logic [DATA_W-1:0]   sRdata;
  logic [3:0]          gnt;
  logic                holdReq;

  modport master (
    input  mReq, mWe, mAddr, mWdata, sAck, sRdata,
    output mAck, mRdata, sReq, sWe, sAddr, sWdata, gnt, holdReq
  );

  modport slave (
    output mReq, mWe, mAddr, mWdata, sAck, sRdata,
    input  mAck, mRdata, sReq, sWe, sAddr, sWdata, gnt, holdReq
  );
endinterface

// File: rtl/bus_arbiter.sv
// Fixed-priority (EX > IF > JTAG > UART) memory-bus arbiter with registered one-hot grant,
// grant locking, burst-limited fairness and a pipeline hold request.

// Per-master slice: gates this master's request fields and the slave ack with its grant bit.
module bus_arbiter_port #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              gnt,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              s_ack,
  output logic              ack,
  output logic              sel_req,
  output logic              sel_we,
  output logic [ADDR_W-1:0] sel_addr,
  output logic [DATA_W-1:0] sel_wdata
);
  assign ack       = s_ack & gnt;
  assign sel_req   = req & gnt;
  assign sel_we    = we & gnt;
  assign sel_addr  = addr & {ADDR_W{gnt}};
  assign sel_wdata = wdata & {DATA_W{gnt}};
endmodule

module bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master bus
);
  localparam int NM = 4;
  localparam int CW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  logic [NM-1:0] gnt_q, gnt_d;
  logic [CW-1:0] burst_q, burst_d;
  logic [NM-1:0] others;

  logic [NM-1:0]             sel_req, sel_we, ack;
  logic [NM-1:0][ADDR_W-1:0] sel_addr;
  logic [NM-1:0][DATA_W-1:0] sel_wdata;
  logic                      s_req, s_we;
  logic [ADDR_W-1:0]         s_addr;
  logic [DATA_W-1:0]         s_wdata;

  function automatic logic [NM-1:0] pick(input logic [NM-1:0] r);
    logic [NM-1:0] p;
    p = '0;
    for (int i = NM-1; i >= 0; i--)
      if (r[i]) begin
        p    = '0;
        p[i] = 1'b1;
      end
    return p;
  endfunction

  genvar g;
  generate
    for (g = 0; g < NM; g++) begin : g_port
      bus_arbiter_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port (
        .gnt      (gnt_q[g]),
        .req      (bus.mReq[g]),
        .we       (bus.mWe[g]),
        .addr     (bus.mAddr[g*ADDR_W +: ADDR_W]),
        .wdata    (bus.mWdata[g*DATA_W +: DATA_W]),
        .s_ack    (bus.sAck),
        .ack      (ack[g]),
        .sel_req  (sel_req[g]),
        .sel_we   (sel_we[g]),
        .sel_addr (sel_addr[g]),
        .sel_wdata(sel_wdata[g])
      );
    end
  endgenerate

  // One-hot grant turns the OR of the gated slices into the slave mux; all-zero when idle.
  always_comb begin
    s_req   = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    for (int i = 0; i < NM; i++) begin
      s_req   = s_req | sel_req[i];
      s_we    = s_we | sel_we[i];
      s_addr  = s_addr | sel_addr[i];
      s_wdata = s_wdata | sel_wdata[i];
    end
  end

  always_comb begin
    others  = bus.mReq & ~gnt_q;
    gnt_d   = gnt_q;
    burst_d = burst_q;
    if (gnt_q == '0)
      gnt_d = pick(bus.mReq);
    else if ((bus.mReq & gnt_q) == '0)
      gnt_d = pick(others);
    else if (burst_q == BURST_LAST && others != '0 && (bus.sAck || !s_req))
      // Forced handover only on a beat boundary; the holder is excluded from the pick.
      gnt_d = pick(others);

    if (gnt_q == '0 || gnt_d != gnt_q)
      burst_d = '0;
    else if (burst_q != BURST_LAST)
      burst_d = burst_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q   <= '0;
      burst_q <= '0;
    end else begin
      gnt_q   <= gnt_d;
      burst_q <= burst_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.mAck   = ack;
  assign bus.mRdata = bus.sRdata;
  assign bus.sReq   = s_req;
  assign bus.sWe    = s_we;
  assign bus.sAddr  = s_addr;
  assign bus.sWdata = s_wdata;

  // Held low during reset so a core stalled by waiting requesters is not also frozen by us.
  assign bus.holdReq = ~rst & ((bus.mReq[0] & ~gnt_q[0]) | (bus.mReq[1] & ~gnt_q[1]) |
                               gnt_q[2] | gnt_q[3]);
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed test-plan scenarios plus random traffic,
// all compared against an owner/cycle-count reference model.
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  int         owner = -1;   // index of the master holding the bus, -1 = idle
  int         held  = 0;    // cycles already spent granted to owner
  logic [3:0] eack;
  logic [3:0] obs_ack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] r, input int excl);
    for (int i = 0; i < 4; i++)
      if (r[i] && i != excl) return i;
    return -1;
  endfunction

  task automatic model_edge();
    int nxt;
    if (owner < 0)
      nxt = lowest(bus.mReq, -1);
    else if (!bus.mReq[owner])
      nxt = lowest(bus.mReq, owner);
    else if (held >= MB-1 && lowest(bus.mReq, owner) >= 0 && bus.sAck)
      nxt = lowest(bus.mReq, owner);
    else
      nxt = owner;
    if (nxt != owner || nxt < 0) held = 0;
    else held++;
    owner = nxt;
  endtask

  task automatic check_outs(input string t);
    logic [3:0]    eg;
    logic          ereq, ewe, ehold;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] ewdata;
    eg = 4'b0; ereq = 1'b0; ewe = 1'b0; eaddr = '0; ewdata = '0;
    if (owner >= 0) begin
      eg[owner] = 1'b1;
      ereq   = bus.mReq[owner];
      ewe    = bus.mWe[owner];
      eaddr  = bus.mAddr[owner*AW +: AW];
      ewdata = bus.mWdata[owner*DW +: DW];
    end
    eack  = bus.sAck ? eg : 4'b0;
    ehold = !rst && ((bus.mReq[0] && owner != 0) || (bus.mReq[1] && owner != 1) ||
                     owner == 2 || owner == 3);
    obs_ack = bus.mAck;
    chk({t, ".gnt"},     bus.gnt,     eg);
    chk({t, ".sReq"},    bus.sReq,    ereq);
    chk({t, ".sWe"},     bus.sWe,     ewe);
    chk({t, ".sAddr"},   bus.sAddr,   eaddr);
    chk({t, ".sWdata"},  bus.sWdata,  ewdata);
    chk({t, ".mAck"},    bus.mAck,    eack);
    chk({t, ".holdReq"}, bus.holdReq, ehold);
    chk({t, ".mRdata"},  bus.mRdata,  bus.sRdata);
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle(input string t);
    #1 check_outs(t);
    @(posedge clk);
    if (rst) begin
      owner = -1;
      held  = 0;
    end else model_edge();
    @(negedge clk);
  endtask

  task automatic new_txn(input int i);
    bus.mReq[i] = 1'b1;
    bus.mWe[i]  = 1'($urandom_range(1, 0));
    bus.mAddr[i*AW +: AW]  = $urandom;
    bus.mWdata[i*DW +: DW] = $urandom;
  endtask

  task automatic go_idle();
    bus.mReq = 4'b0;
    bus.sAck = 1'b0;
    cycle("idle");
    cycle("idle");
  endtask

  // Master 2 streams; master 0 joins at k=3; sAck is withheld on cycles listed in nack.
  task automatic burst_run(input string t, input int nack_lo, input int nack_hi,
                           input int exp_cycles);
    int cyc, acks;
    cyc = 0; acks = 0;
    bus.mReq = 4'b0100; bus.sAck = 1'b1;
    cycle(t);
    for (int k = 0; k < 40; k++) begin
      if (k == 3) bus.mReq[0] = 1'b1;
      bus.sAck = !(k >= nack_lo && k <= nack_hi);
      cycle(t);
      cyc++;
      if (obs_ack[2]) acks++;
      if (bus.gnt !== 4'b0100) break;
    end
    chk({t, ".granted_cycles"}, 64'(cyc), 64'(exp_cycles));
    chk({t, ".ack2_count"},     64'(acks), 64'(MB));
    chk({t, ".new_gnt"},        bus.gnt,   4'b0001);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.mReq = 4'b1111; bus.mWe = 4'b0; bus.mAddr = '0; bus.mWdata = '0;
    bus.sAck = 1'b0; bus.sRdata = '0;
    @(negedge clk);

    // Reset with every master requesting
    cycle("reset");
    chk("reset.gnt", bus.gnt, 4'b0000);
    chk("reset.hold", bus.holdReq, 1'b0);
    rst = 1'b0;
    cycle("rel");
    chk("rel.gnt", bus.gnt, 4'b0001);
    go_idle();

    // Priority and release handover
    bus.mReq = 4'b0110;
    cycle("prio");
    chk("prio.gnt", bus.gnt, 4'b0010);
    #1 chk("prio.hold", bus.holdReq, 1'b0);
    bus.mReq = 4'b0100;
    cycle("prio_rel");
    chk("prio_rel.gnt", bus.gnt, 4'b0100);
    #1 chk("prio_rel.hold", bus.holdReq, 1'b1);
    @(negedge clk);
    go_idle();

    // Burst limit, then deferred handover with sAck low at the limit cycle and one after
    burst_run("burst", -1, -1, MB);
    go_idle();
    burst_run("defer", MB-1, MB, MB+2);
    go_idle();

    // Fetch blocked by EX
    bus.mReq = 4'b0011;
    cycle("fetch");
    chk("fetch.gnt", bus.gnt, 4'b0001);
    for (int k = 0; k < 3; k++) cycle("fetch_wait");
    bus.mReq = 4'b0010;
    cycle("fetch_rel");
    chk("fetch_rel.gnt", bus.gnt, 4'b0010);
    go_idle();

    // Mid-transfer reset during a UART write
    bus.mReq = 4'b1000; bus.mWe = 4'b1000;
    bus.mAddr[3*AW +: AW] = 32'h1000_0004; bus.mWdata[3*DW +: DW] = 32'hCAFE_F00D;
    cycle("uart");
    chk("uart.sAddr", bus.sAddr, 32'h1000_0004);
    #2 rst = 1'b1;
    #1;
    chk("midrst.sReq", bus.sReq, 1'b0);
    chk("midrst.sWe", bus.sWe, 1'b0);
    chk("midrst.sAddr", bus.sAddr, 32'h0);
    chk("midrst.gnt", bus.gnt, 4'b0);
    owner = -1; held = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle("restart");
    chk("restart.gnt", bus.gnt, 4'b1000);
    go_idle();

    // Random traffic; masters hold each transaction until acked
    eack = 4'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.mReq[i] && eack[i]) begin
          if ($urandom_range(1, 0) == 0) bus.mReq[i] = 1'b0;
          else new_txn(i);
        end else if (!bus.mReq[i] && $urandom_range(3, 0) == 0) new_txn(i);
      end
      bus.sAck   = ($urandom_range(2, 0) != 0);
      bus.sRdata = $urandom;
      cycle("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
